// File: rtl/bar_array_loader.sv
// Fills the sorter's bar-height array with LFSR-generated values, one write per accepted cycle.
// Optional build macro BAR_MIN_CLAMP_EN raises every bar below MIN_H to MIN_H.
module bar_array_loader #(
    parameter int unsigned N_BARS       = 32,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned DATA_W       = 8,
    parameter logic [15:0] DEFAULT_SEED = 16'hACE1,
    parameter int unsigned MIN_H        = 8
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [15:0]       seed_i,
    input  logic              wr_ready_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {StIdle, StSeed, StFill, StDone} state_e;

    state_e            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        lfsr_byte;
    logic              last_idx;

    assign lfsr_byte = lfsr_q[7:0];
    assign last_idx  = (idx_q == ADDR_W'(N_BARS - 1));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= StIdle;
            lfsr_q  <= DEFAULT_SEED;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        idx_d   = idx_q;
        wr_en_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                // start beats a simultaneous abort; abort alone means nothing here
                if (start_i) begin
                    lfsr_d  = (seed_i == 16'h0000) ? DEFAULT_SEED : seed_i;
                    idx_d   = '0;
                    state_d = StSeed;
                end
            end
            StSeed: begin
                state_d = abort_i ? StIdle : StFill;
            end
            StFill: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else if (wr_ready_i) begin
                    wr_en_o = 1'b1;
                    idx_d   = idx_q + 1'b1;
                    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
                    if (last_idx) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign wr_addr_o = idx_q;
    assign busy_o    = (state_q == StSeed) || (state_q == StFill);
    assign done_o    = (state_q == StDone);

`ifdef BAR_MIN_CLAMP_EN
    assign wr_data_o = (lfsr_byte < 8'(MIN_H)) ? DATA_W'(8'(MIN_H)) : DATA_W'(lfsr_byte);
`else
    assign wr_data_o = DATA_W'(lfsr_byte);

    logic [31:0] unused_min_h;
    assign unused_min_h = MIN_H;
`endif

endmodule
